shift_32_reader: RTL and testbench

Read-side sequencer for the shift_32 line memory (71 x 32-bit words; each word holds 4 x 8-bit pixels).
- Drives the memory's addr port with write_en held low.
- Fetches three vertically aligned words (rows r, r+1, r+2) and presents them as one 96-bit window to the downstream Sobel stage over a valid/ready handshake.
- Walks a programmable number of consecutive columns per start command.

---
 rtl/shift_32_pkg.sv | 22 ++
 rtl/shift_32_addr_wrap.sv | 20 ++
 rtl/shift_32_reader.sv | 172 +++++++++++++++++
 tb/tb_shift_32_reader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_32_pkg.sv
// Shared constants and types for the shift_32 line-memory read sequencer.
package shift_32_pkg;

    localparam int unsigned DEPTH     = 71;
    localparam int unsigned ROW_WORDS = 23;
    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned WIN_W     = 3 * DATA_W;
    localparam int unsigned WCNT_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_PRESENT,
        ST_DONE
    } state_t;

    // Row slot inside the window: 0 = top, 1 = middle, 2 = bottom.
    typedef logic [1:0] slot_t;

endpackage

// File: rtl/shift_32_addr_wrap.sv
// Combinational modulo-DEPTH adder; both operands must already be < DEPTH.
module shift_32_addr_wrap
    import shift_32_pkg::*;
(
    input  logic [ADDR_W-1:0] i_a,
    input  logic [ADDR_W-1:0] i_b,
    output logic [ADDR_W-1:0] o_sum_c
);

    localparam int unsigned SUM_W = ADDR_W + 1;

    logic [SUM_W-1:0] w_raw;
    logic [SUM_W-1:0] w_red;

    // Sum is < 2*DEPTH, so a single conditional subtract suffices.
    assign w_raw   = {1'b0, i_a} + {1'b0, i_b};
    assign w_red   = (w_raw >= SUM_W'(DEPTH)) ? (w_raw - SUM_W'(DEPTH)) : w_raw;
    assign o_sum_c = w_red[ADDR_W-1:0];

endmodule

// File: rtl/shift_32_reader.sv
// Read sequencer for shift_32: fetches rows r, r+ROW_WORDS, r+2*ROW_WORDS as one window.
// Optional SHIFT_32_READER_WIN_COUNT_EN adds a saturating win_count handshake counter.
module shift_32_reader
    import shift_32_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [WIN_W-1:0]  win_data
`ifdef SHIFT_32_READER_WIN_COUNT_EN
    ,
    output logic [WCNT_W-1:0] win_count
`endif
);

    localparam int unsigned LAST = RD_LATENCY - 1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_rem;
    slot_t             r_iss;
    logic [1:0]        r_drn;
    logic              r_tag_vld  [RD_LATENCY];
    slot_t             r_tag_slot [RD_LATENCY];
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_win_valid;
    logic [WIN_W-1:0]  r_win_data;

    logic [ADDR_W-1:0] w_row_next;
    logic [ADDR_W-1:0] w_ptr_next;

    shift_32_addr_wrap u_row_wrap (
        .i_a     (r_mem_addr),
        .i_b     (ADDR_W'(ROW_WORDS)),
        .o_sum_c (w_row_next)
    );

    shift_32_addr_wrap u_col_wrap (
        .i_a     (r_ptr),
        .i_b     (ADDR_W'(1)),
        .o_sum_c (w_ptr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_rem       <= '0;
            r_iss       <= '0;
            r_drn       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_addr  <= '0;
            r_win_valid <= 1'b0;
            r_win_data  <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_tag_vld[i]  <= 1'b0;
                r_tag_slot[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;

            // Tag pipeline tracks which row slot the returning read data belongs to.
            r_tag_vld[0]  <= (r_state == ST_ISSUE);
            r_tag_slot[0] <= r_iss;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_slot[i] <= r_tag_slot[i-1];
            end
            if (r_tag_vld[LAST]) begin
                case (r_tag_slot[LAST])
                    2'd0:    r_win_data[DATA_W-1:0]          <= mem_rd_data;
                    2'd1:    r_win_data[2*DATA_W-1:DATA_W]   <= mem_rd_data;
                    default: r_win_data[3*DATA_W-1:2*DATA_W] <= mem_rd_data;
                endcase
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            r_ptr      <= base_addr;
                            r_rem      <= count;
                            r_mem_addr <= base_addr;
                            r_iss      <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= ST_ISSUE;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_iss == 2'd2) begin
                        r_drn   <= 2'(RD_LATENCY - 1);
                        r_state <= ST_DRAIN;
                    end else begin
                        r_mem_addr <= w_row_next;
                        r_iss      <= r_iss + 2'd1;
                    end
                end
                ST_DRAIN: begin
                    if (r_drn == 2'd0) begin
                        r_win_valid <= 1'b1;
                        r_state     <= ST_PRESENT;
                    end else begin
                        r_drn <= r_drn - 2'd1;
                    end
                end
                ST_PRESENT: begin
                    if (win_ready) begin
                        r_win_valid <= 1'b0;
                        r_ptr       <= w_ptr_next;
                        r_rem       <= r_rem - ADDR_W'(1);
                        if (r_rem != ADDR_W'(1)) begin
                            r_mem_addr <= w_ptr_next;
                            r_iss      <= '0;
                            r_state    <= ST_ISSUE;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SHIFT_32_READER_WIN_COUNT_EN
    logic [WCNT_W-1:0] r_win_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_count <= '0;
        end else if ((r_state == ST_PRESENT) && win_ready && (r_win_count != '1)) begin
            r_win_count <= r_win_count + WCNT_W'(1);
        end
    end

    assign win_count = r_win_count;
`endif

    assign busy         = r_busy;
    assign done         = r_done;
    assign mem_addr     = r_mem_addr;
    assign mem_write_en = 1'b0;
    assign win_valid    = r_win_valid;
    assign win_data     = r_win_data;

endmodule

// File: tb/tb_shift_32_reader.sv
// Self-checking bench for shift_32_reader against a modulo-arithmetic window model.
module tb_shift_32_reader;

    localparam int DEPTH = 71;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  base_addr;
    logic [6:0]  count;
    logic        busy;
    logic        done;
    logic [6:0]  mem_addr;
    logic        mem_write_en;
    logic [31:0] mem_rd_data;
    logic        win_valid;
    logic        win_ready;
    logic [95:0] win_data;
`ifdef SHIFT_32_READER_WIN_COUNT_EN
    logic [15:0] win_count;
`endif

    logic [31:0] mem [0:127];
    int n_cmp = 0;
    int n_err = 0;
    int n_hs  = 0;

    shift_32_reader #(.RD_LATENCY(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .count        (count),
        .busy         (busy),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_write_en (mem_write_en),
        .mem_rd_data  (mem_rd_data),
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .win_data     (win_data)
`ifdef SHIFT_32_READER_WIN_COUNT_EN
        ,
        .win_count    (win_count)
`endif
    );

    always #5 clk = ~clk;

    // Line memory with one cycle of read latency.
    always @(posedge clk) mem_rd_data <= mem[mem_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] exp_win(input int p);
        return {mem[(p + 46) % DEPTH], mem[(p + 23) % DEPTH], mem[p % DEPTH]};
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_valid"}, win_valid, 0);
        chk({tag, "_addr"},  mem_addr, 0);
        chk({tag, "_data"},  win_data, 0);
        chk({tag, "_wen"},   mem_write_en, 0);
    endtask

    // One start command; stall < 0 picks a random 0..3 cycle stall per window.
    task automatic run_job(input int base, input int cnt, input int stall, input bit mid);
        int p;
        int cyc;
        int ns;
        base_addr = 7'(base);
        count     = 7'(cnt);
        start     = 1'b1;
        tick();
        start = 1'b0;
        if (cnt == 0) begin
            chk("zc_done",  done, 1);
            chk("zc_busy",  busy, 0);
            chk("zc_valid", win_valid, 0);
            tick();
            chk("zc_done_end",  done, 0);
            chk("zc_valid_end", win_valid, 0);
            return;
        end
        chk("busy_start", busy, 1);
        p = base;
        for (int k = 0; k < cnt; k++) begin
            cyc = 1;
            forever begin
                if (cyc <= 3) chk("issue_addr", mem_addr, 96'((p + 23 * (cyc - 1)) % DEPTH));
                if (mid && k == 0 && cyc == 1) begin
                    start     = 1'b1;
                    base_addr = 7'((base + 17) % DEPTH);
                    count     = 7'd2;
                end else begin
                    start = 1'b0;
                end
                if (win_valid || cyc >= 64) break;
                win_ready = 1'($urandom_range(0, 1));
                tick();
                cyc++;
            end
            win_ready = 1'b0;
            chk("latency", 96'(cyc), 96'd5);
            chk("win_data", win_data, exp_win(p));
            chk("busy_present", busy, 1);
            ns = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int s = 0; s < ns; s++) begin
                tick();
                chk("stall_valid", win_valid, 1);
                chk("stall_data", win_data, exp_win(p));
                chk("stall_addr", mem_addr, 96'((p + 46) % DEPTH));
                chk("stall_busy", busy, 1);
                chk("stall_done", done, 0);
            end
            win_ready = 1'b1;
            tick();
            win_ready = 1'b0;
            n_hs++;
            p = (p + 1) % DEPTH;
            if (k < cnt - 1) chk("valid_drop", win_valid, 0);
        end
        chk("done_pulse", done, 1);
        chk("done_busy",  busy, 0);
        chk("done_valid", win_valid, 0);
        tick();
        chk("done_end", done, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        win_ready = 1'b0;
        base_addr = '0;
        count     = '0;
        for (int i = 0; i < 128; i++) mem[i] = 32'(i);
        tick();
        tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // Directed windows over an identity-filled memory.
        run_job(0, 1, 0, 1'b0);
        chk("first_window_top", win_data[31:0], 0);
        run_job(69, 3, 0, 1'b0);
        run_job(30, 1, 0, 1'b0);
        run_job(10, 1, 10, 1'b0);
        run_job(5, 1, 0, 1'b1);
        run_job(7, 0, 0, 1'b0);

        // Reset while draining discards the in-flight capture.
        base_addr = 7'd12;
        count     = 7'd2;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_reset("rst_drain");
        rst = 1'b0;
        tick();
        run_job(50, 2, -1, 1'b0);

        // Random memory contents and commands.
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        for (int j = 0; j < 10; j++) begin
            run_job(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 4)), -1, 1'b0);
            if (($urandom_range(0, 3)) == 0) run_job(int'($urandom_range(0, DEPTH - 1)), 0, 0, 1'b0);
        end

`ifdef SHIFT_32_READER_WIN_COUNT_EN
        rst = 1'b1;
        tick();
        chk("wc_reset", win_count, 0);
        rst = 1'b0;
        tick();
        run_job(3, 5, -1, 1'b0);
        run_job(40, 5, -1, 1'b0);
        chk("win_count", win_count, 10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
